rv32v_memory_stage: RTL and testbench
=====================================

Name: rv32v_memory_stage

Overview:
- Consumer end of the execute→memory pipeline latch in the RV32V vector unit.
- Takes the registered two-lane execute result: lane addresses for loads/stores, or ALU results otherwise.
- Serialises lane 0 then lane 1 accesses onto the single data-memory port, collecting load data or issuing store data.
- Drives the memory→writeback latch and holds upstream stages with busy_mem until the access sequence completes.

Parameters:
- WOFF_W, 5: width of woffset0/woffset1 (element offset within the destination register group).
- VTYPE_W, 8: width of the vtype field.

Ports:
- CLK  in  1  clock, all state on posedge.
- nRST  in  1  asynchronous active-low reset.
- load, store  in  1 each  execute→memory latch: the instruction is a vector load or store.
- ena0, ena1  in  1 each  lane element active (unmasked and offset < vl); inactive lanes issue no memory access.
- aluresult0, aluresult1  in  32 each  lane address (load/store) or lane ALU result.
- storedata0, storedata1  in  32 each  lane store data.
- wen0, wen1  in  1 each  lane vector-register write enable.
- woffset0, woffset1  in  WOFF_W each  lane element offset.
- config_type  in  1  vset{i}vl{i} instruction.
- vl  in  32  vector length.
- vtype  in  VTYPE_W  vector type.
- stall_mem  in  1  hazard unit: hold the memory→writeback latch.
- flush_mem  in  1  hazard unit: kill the instruction in the memory stage.
- busy_mem  out  1  to hazard unit: memory sequence in progress; upstream must hold the execute→memory latch.
- dmem_ren, dmem_wen  out  1 each  data-memory read/write request (word access).
- dmem_addr  out  32  request address.
- dmem_wdata  out  32  store data.
- dmem_rdata  in  32  load data, valid in the cycle dmem_busy is low.
- dmem_busy  in  1  request not yet accepted; request signals stay stable while it is high.
- wb_wen0, wb_wen1  out  1 each  writeback lane enables.
- wb_wdat0, wb_wdat1  out  32 each  writeback lane data.
- wb_woffset0, wb_woffset1  out  WOFF_W each  writeback offsets.
- wb_config_type  out  1  registered config_type.
- wb_vl  out  32  registered vl.
- wb_vtype  out  VTYPE_W  registered vtype.

Behaviour:
- FSM states: IDLE, LANE0, LANE1, DONE. Reset state is IDLE; all wb_* outputs reset to 0; the lane data buffers rdbuf0/rdbuf1 reset to 0.
- busy_mem = (IDLE & (load|store) & (ena0|ena1)) | LANE0 | LANE1.
- In DONE, busy_mem = 0.
- IDLE → LANE0 when ls & ena0; IDLE → LANE1 when ls & !ena0 & ena1.
- A load/store with no active lane behaves as a non-memory instruction; its wb_wen is forced to 0 for inactive lanes.
- LANE0:
  - Drive dmem_addr = aluresult0; dmem_ren = load, dmem_wen = store; dmem_wdata = storedata0.
  - On !dmem_busy, capture rdbuf0 = dmem_rdata (loads only).
  - Then go to LANE1 if ena1, else DONE.
- LANE1: same as LANE0 with aluresult1/storedata1/rdbuf1; on !dmem_busy go to DONE.
- DONE:
  - If !stall_mem, the latch captures and the FSM goes to IDLE.
  - If stall_mem, stay in DONE with the buffers held.
- dmem_ren and dmem_wen are 0 outside LANE0/LANE1.
- Writeback latch update (on !stall_mem when state is IDLE with busy_mem = 0, or DONE):
  - wb_wdatN = load ? rdbufN : aluresultN.
  - wb_wenN = wenN & (load ? enaN : 1).
  - All other fields pass through.
  - Stores write wb_wen* = 0.
- Latency with zero-wait memory:
  - Non-memory instruction: 1 cycle.
  - Two-lane load/store: 4 cycles (IDLE, LANE0, LANE1, DONE).
  - One-lane load/store: 3 cycles.
- flush_mem has priority over stall_mem. Any state → IDLE, wb_* cleared to 0 next edge.
  - An in-flight request is dropped: request signals deassert the next cycle.
  - A completed lane-0 store is not undone.
- Asynchronous reset mid-sequence returns the FSM to IDLE with no request asserted.

Optional Feature:
- Macro RV32V_MEM_ALIGN_CHECK_EN.
- Defined:
  - A lane address with addr[1:0] != 0 issues no dmem request; that lane completes in one cycle with data 0 and wb_wen 0.
  - Extra output misaligned (1 bit) pulses high for one cycle in DONE if any lane was misaligned; it resets to 0.
- Undefined: the misaligned port is absent, and addresses pass to dmem_addr unmodified.

Test Plan:
- Add, non-memory: aluresult0 = 0x5, aluresult1 = 0x7, wen0 = wen1 = 1 → next edge wb_wdat0 = 5, wb_wdat1 = 7, wb_wen = 11, busy_mem never high.
- Load, both lanes, aluresult0 = 0x100, aluresult1 = 0x104, memory returns 0xAA then 0xBB, zero wait → dmem_addr 0x100 then 0x104 in consecutive cycles; wb_wdat0 = 0xAA, wb_wdat1 = 0xBB after 4 cycles; busy_mem high for 3 cycles.
- Store, ena1 = 0, aluresult0 = 0x200, storedata0 = 0x1234, dmem_busy high for 2 cycles → dmem_wen held with stable address/data for 3 cycles, no lane-1 access, wb_wen0 = wb_wen1 = 0.
- Load in DONE with stall_mem = 1 for 2 cycles → state stays DONE, wb_* unchanged; latches on the first cycle stall_mem = 0.
- flush_mem asserted in LANE1 → dmem_ren = 0 next cycle, state IDLE, all wb_* = 0.
- With RV32V_MEM_ALIGN_CHECK_EN: load aluresult0 = 0x102 → no dmem request for lane 0, misaligned = 1 for one cycle, wb_wen0 = 0.

Source files
------------

// File: rtl/rv32v_memory_stage.sv
// RV32V memory stage: serialises two vector lanes onto one data-memory port.
// Optional RV32V_MEM_ALIGN_CHECK_EN suppresses misaligned lane accesses.
module rv32v_memory_stage #(
   parameter int WOFF_W  = 5,
   parameter int VTYPE_W = 8
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               load,
   input  logic               store,
   input  logic               ena0,
   input  logic               ena1,
   input  logic [31:0]        aluresult0,
   input  logic [31:0]        aluresult1,
   input  logic [31:0]        storedata0,
   input  logic [31:0]        storedata1,
   input  logic               wen0,
   input  logic               wen1,
   input  logic [WOFF_W-1:0]  woffset0,
   input  logic [WOFF_W-1:0]  woffset1,
   input  logic               config_type,
   input  logic [31:0]        vl,
   input  logic [VTYPE_W-1:0] vtype,
   input  logic               stall_mem,
   input  logic               flush_mem,
   output logic               busy_mem,
   output logic               dmem_ren,
   output logic               dmem_wen,
   output logic [31:0]        dmem_addr,
   output logic [31:0]        dmem_wdata,
   input  logic [31:0]        dmem_rdata,
   input  logic               dmem_busy,
   output logic               wb_wen0,
   output logic               wb_wen1,
   output logic [31:0]        wb_wdat0,
   output logic [31:0]        wb_wdat1,
   output logic [WOFF_W-1:0]  wb_woffset0,
   output logic [WOFF_W-1:0]  wb_woffset1,
   output logic               wb_config_type,
   output logic [31:0]        wb_vl,
   output logic [VTYPE_W-1:0] wb_vtype
`ifdef RV32V_MEM_ALIGN_CHECK_EN
   ,
   output logic               misaligned
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LANE0,
      S_LANE1,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_rdbuf0;
   logic [31:0] r_rdbuf1;
   logic        w_ls;
   logic        w_mis0;
   logic        w_mis1;
   logic        w_cap0;
   logic        w_cap1;
   logic        w_wb_upd;

   assign w_ls = load | store;

`ifdef RV32V_MEM_ALIGN_CHECK_EN
   assign w_mis0 = |aluresult0[1:0];
   assign w_mis1 = |aluresult1[1:0];
`else
   assign w_mis0 = 1'b0;
   assign w_mis1 = 1'b0;
`endif

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      busy_mem   = 1'b0;
      dmem_ren   = 1'b0;
      dmem_wen   = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      w_cap0     = 1'b0;
      w_cap1     = 1'b0;
      w_wb_upd   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_ls & (ena0 | ena1)) begin
               busy_mem = 1'b1;
               w_next   = ena0 ? S_LANE0 : S_LANE1;
            end else begin
               w_wb_upd = ~stall_mem;
            end
         end
         S_LANE0: begin
            busy_mem = 1'b1;
            if (w_mis0) begin
               w_cap0 = load;
               w_next = ena1 ? S_LANE1 : S_DONE;
            end else begin
               dmem_ren   = load;
               dmem_wen   = store;
               dmem_addr  = aluresult0;
               dmem_wdata = storedata0;
               if (!dmem_busy) begin
                  w_cap0 = load;
                  w_next = ena1 ? S_LANE1 : S_DONE;
               end
            end
         end
         S_LANE1: begin
            busy_mem = 1'b1;
            if (w_mis1) begin
               w_cap1 = load;
               w_next = S_DONE;
            end else begin
               dmem_ren   = load;
               dmem_wen   = store;
               dmem_addr  = aluresult1;
               dmem_wdata = storedata1;
               if (!dmem_busy) begin
                  w_cap1 = load;
                  w_next = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (!stall_mem) begin
               w_wb_upd = 1'b1;
               w_next   = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
      // flush wins over stall and any in-flight lane request
      if (flush_mem) begin
         w_next   = S_IDLE;
         w_wb_upd = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_rdbuf0 <= '0;
         r_rdbuf1 <= '0;
      end else begin
         if (w_cap0) r_rdbuf0 <= w_mis0 ? 32'd0 : dmem_rdata;
         if (w_cap1) r_rdbuf1 <= w_mis1 ? 32'd0 : dmem_rdata;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wb_wen0        <= 1'b0;
         wb_wen1        <= 1'b0;
         wb_wdat0       <= '0;
         wb_wdat1       <= '0;
         wb_woffset0    <= '0;
         wb_woffset1    <= '0;
         wb_config_type <= 1'b0;
         wb_vl          <= '0;
         wb_vtype       <= '0;
      end else if (flush_mem) begin
         wb_wen0        <= 1'b0;
         wb_wen1        <= 1'b0;
         wb_wdat0       <= '0;
         wb_wdat1       <= '0;
         wb_woffset0    <= '0;
         wb_woffset1    <= '0;
         wb_config_type <= 1'b0;
         wb_vl          <= '0;
         wb_vtype       <= '0;
      end else if (w_wb_upd) begin
         wb_wen0        <= wen0 & ~store & (~load | (ena0 & ~w_mis0));
         wb_wen1        <= wen1 & ~store & (~load | (ena1 & ~w_mis1));
         wb_wdat0       <= load ? r_rdbuf0 : aluresult0;
         wb_wdat1       <= load ? r_rdbuf1 : aluresult1;
         wb_woffset0    <= woffset0;
         wb_woffset1    <= woffset1;
         wb_config_type <= config_type;
         wb_vl          <= vl;
         wb_vtype       <= vtype;
      end
   end

`ifdef RV32V_MEM_ALIGN_CHECK_EN
   logic r_mis;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) r_mis <= 1'b0;
      else       r_mis <= (w_next == S_DONE) && (r_state != S_DONE) &&
                          ((ena0 & w_mis0) | (ena1 & w_mis1));
   end

   assign misaligned = r_mis;
`endif

endmodule

// File: tb/tb_rv32v_memory_stage.sv
// Directed self-checking bench for rv32v_memory_stage.
// Scenario tasks run in sequence from one initial block.
module tb_rv32v_memory_stage;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        load, store, ena0, ena1;
   logic [31:0] aluresult0, aluresult1, storedata0, storedata1;
   logic        wen0, wen1;
   logic [4:0]  woffset0, woffset1;
   logic        config_type;
   logic [31:0] vl;
   logic [7:0]  vtype;
   logic        stall_mem, flush_mem;
   logic        busy_mem, dmem_ren, dmem_wen;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_busy;
   logic        wb_wen0, wb_wen1;
   logic [31:0] wb_wdat0, wb_wdat1;
   logic [4:0]  wb_woffset0, wb_woffset1;
   logic        wb_config_type;
   logic [31:0] wb_vl;
   logic [7:0]  wb_vtype;
`ifdef RV32V_MEM_ALIGN_CHECK_EN
   logic        misaligned;
`endif

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   always_comb begin
      case (dmem_addr)
         32'h100: dmem_rdata = 32'hAA;
         32'h104: dmem_rdata = 32'hBB;
         32'h108: dmem_rdata = 32'hCC;
         32'h10C: dmem_rdata = 32'hDD;
         default: dmem_rdata = 32'hDEAD_BEEF;
      endcase
   end

   rv32v_memory_stage #(.WOFF_W(5), .VTYPE_W(8)) dut (
      .CLK(CLK), .nRST(nRST),
      .load(load), .store(store), .ena0(ena0), .ena1(ena1),
      .aluresult0(aluresult0), .aluresult1(aluresult1),
      .storedata0(storedata0), .storedata1(storedata1),
      .wen0(wen0), .wen1(wen1),
      .woffset0(woffset0), .woffset1(woffset1),
      .config_type(config_type), .vl(vl), .vtype(vtype),
      .stall_mem(stall_mem), .flush_mem(flush_mem),
      .busy_mem(busy_mem),
      .dmem_ren(dmem_ren), .dmem_wen(dmem_wen),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_busy(dmem_busy),
      .wb_wen0(wb_wen0), .wb_wen1(wb_wen1),
      .wb_wdat0(wb_wdat0), .wb_wdat1(wb_wdat1),
      .wb_woffset0(wb_woffset0), .wb_woffset1(wb_woffset1),
      .wb_config_type(wb_config_type), .wb_vl(wb_vl), .wb_vtype(wb_vtype)
`ifdef RV32V_MEM_ALIGN_CHECK_EN
      , .misaligned(misaligned)
`endif
   );

   task automatic clear_inputs();
      load = 0; store = 0; ena0 = 0; ena1 = 0;
      aluresult0 = 0; aluresult1 = 0; storedata0 = 0; storedata1 = 0;
      wen0 = 0; wen1 = 0; woffset0 = 0; woffset1 = 0;
      config_type = 0; vl = 0; vtype = 0;
      stall_mem = 0; flush_mem = 0; dmem_busy = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      nRST = 0;
      #12;
      total++;
      if ({busy_mem, dmem_ren, dmem_wen} !== 3'b000) begin
         bad++;
         $display("FAIL reset_req got=%b want=000", {busy_mem, dmem_ren, dmem_wen});
      end
      total++;
      if ({wb_wen0, wb_wen1, wb_config_type} !== 3'b000 || wb_wdat0 !== 0 ||
          wb_wdat1 !== 0 || wb_vl !== 0 || wb_vtype !== 0) begin
         bad++;
         $display("FAIL reset_wb got wdat0=%h wdat1=%h vl=%h want all zero",
                  wb_wdat0, wb_wdat1, wb_vl);
      end
      @(negedge CLK); nRST = 1;
      @(posedge CLK); #1;
   endtask

   task automatic test_alu();
      aluresult0 = 32'h5; aluresult1 = 32'h7; wen0 = 1; wen1 = 1;
      ena0 = 1; ena1 = 1;
      woffset0 = 5'd3; woffset1 = 5'd4; config_type = 1;
      vl = 32'd16; vtype = 8'h42;
      @(negedge CLK);
      total++;
      if (busy_mem !== 1'b0) begin
         bad++; $display("FAIL alu_busy got=%b want=0", busy_mem);
      end
      @(posedge CLK); #1;
      total++;
      if (wb_wdat0 !== 32'h5 || wb_wdat1 !== 32'h7) begin
         bad++; $display("FAIL alu_wdat got=%h,%h want=5,7", wb_wdat0, wb_wdat1);
      end
      total++;
      if ({wb_wen0, wb_wen1} !== 2'b11) begin
         bad++; $display("FAIL alu_wen got=%b want=11", {wb_wen0, wb_wen1});
      end
      total++;
      if (wb_woffset0 !== 5'd3 || wb_woffset1 !== 5'd4 || wb_vl !== 32'd16 ||
          wb_vtype !== 8'h42 || wb_config_type !== 1'b1) begin
         bad++;
         $display("FAIL alu_pass got off=%0d,%0d vl=%0d vt=%h cfg=%b want 3,4 16 42 1",
                  wb_woffset0, wb_woffset1, wb_vl, wb_vtype, wb_config_type);
      end
      clear_inputs();
   endtask

   task automatic test_load2();
      int nbusy = 0;
      load = 1; ena0 = 1; ena1 = 1; wen0 = 1; wen1 = 1;
      aluresult0 = 32'h100; aluresult1 = 32'h104;
      @(negedge CLK); if (busy_mem) nbusy++;
      total++;
      if (dmem_ren !== 1'b0) begin
         bad++; $display("FAIL ld2_idle_ren got=%b want=0", dmem_ren);
      end
      @(negedge CLK); if (busy_mem) nbusy++;
      total++;
      if (dmem_ren !== 1'b1 || dmem_addr !== 32'h100) begin
         bad++; $display("FAIL ld2_lane0 got ren=%b addr=%h want 1 100", dmem_ren, dmem_addr);
      end
      @(negedge CLK); if (busy_mem) nbusy++;
      total++;
      if (dmem_ren !== 1'b1 || dmem_addr !== 32'h104) begin
         bad++; $display("FAIL ld2_lane1 got ren=%b addr=%h want 1 104", dmem_ren, dmem_addr);
      end
      @(negedge CLK); if (busy_mem) nbusy++;
      total++;
      if (dmem_ren !== 1'b0 || nbusy != 3) begin
         bad++; $display("FAIL ld2_done got ren=%b busy_cycles=%0d want 0 3", dmem_ren, nbusy);
      end
      @(posedge CLK); #1;
      total++;
      if (wb_wdat0 !== 32'hAA || wb_wdat1 !== 32'hBB || {wb_wen0, wb_wen1} !== 2'b11) begin
         bad++;
         $display("FAIL ld2_wb got=%h,%h wen=%b want=aa,bb 11", wb_wdat0, wb_wdat1,
                  {wb_wen0, wb_wen1});
      end
      clear_inputs();
   endtask

   task automatic test_load1();
      load = 1; ena0 = 0; ena1 = 1; wen0 = 1; wen1 = 1;
      aluresult0 = 32'h100; aluresult1 = 32'h104;
      @(posedge CLK);
      @(negedge CLK);
      total++;
      if (dmem_ren !== 1'b1 || dmem_addr !== 32'h104) begin
         bad++; $display("FAIL ld1_lane1 got ren=%b addr=%h want 1 104", dmem_ren, dmem_addr);
      end
      @(posedge CLK);
      @(posedge CLK); #1;
      total++;
      if ({wb_wen0, wb_wen1} !== 2'b01 || wb_wdat1 !== 32'hBB) begin
         bad++;
         $display("FAIL ld1_wb got wen=%b wdat1=%h want 01 bb", {wb_wen0, wb_wen1}, wb_wdat1);
      end
      ena1 = 0;
      @(negedge CLK);
      total++;
      if (busy_mem !== 1'b0) begin
         bad++; $display("FAIL ld0_busy got=%b want=0", busy_mem);
      end
      @(posedge CLK); #1;
      total++;
      if ({wb_wen0, wb_wen1} !== 2'b00) begin
         bad++; $display("FAIL ld0_wen got=%b want=00", {wb_wen0, wb_wen1});
      end
      clear_inputs();
   endtask

   task automatic test_store_wait();
      store = 1; ena0 = 1; ena1 = 0; wen0 = 1; wen1 = 1;
      aluresult0 = 32'h200; storedata0 = 32'h1234;
      aluresult1 = 32'h300; storedata1 = 32'h5678;
      dmem_busy = 1;
      @(posedge CLK); #1;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) dmem_busy = 0;
         @(negedge CLK);
         total++;
         if (dmem_wen !== 1'b1 || dmem_ren !== 1'b0 || dmem_addr !== 32'h200 ||
             dmem_wdata !== 32'h1234) begin
            bad++;
            $display("FAIL st_hold%0d got wen=%b addr=%h data=%h want 1 200 1234",
                     i, dmem_wen, dmem_addr, dmem_wdata);
         end
         @(posedge CLK); #1;
      end
      @(negedge CLK);
      total++;
      if (dmem_wen !== 1'b0 || busy_mem !== 1'b0) begin
         bad++; $display("FAIL st_no_lane1 got wen=%b busy=%b want 0 0", dmem_wen, busy_mem);
      end
      @(posedge CLK); #1;
      total++;
      if ({wb_wen0, wb_wen1} !== 2'b00 || wb_wdat0 !== 32'h200) begin
         bad++;
         $display("FAIL st_wb got wen=%b wdat0=%h want 00 200", {wb_wen0, wb_wen1}, wb_wdat0);
      end
      clear_inputs();
   endtask

   task automatic test_stall();
      aluresult0 = 32'h77; aluresult1 = 32'h66; wen0 = 1; wen1 = 1;
      @(posedge CLK); #1;
      load = 1; ena0 = 1; ena1 = 1; stall_mem = 1;
      aluresult0 = 32'h108; aluresult1 = 32'h10C; vl = 32'd9;
      repeat (3) @(posedge CLK);
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         total++;
         if (busy_mem !== 1'b0 || dmem_ren !== 1'b0 || wb_wdat0 !== 32'h77 ||
             wb_wdat1 !== 32'h66) begin
            bad++;
            $display("FAIL stall_hold%0d got busy=%b ren=%b wdat=%h,%h want 0 0 77,66",
                     i, busy_mem, dmem_ren, wb_wdat0, wb_wdat1);
         end
         @(posedge CLK);
      end
      #1 stall_mem = 0;
      @(posedge CLK); #1;
      total++;
      if (wb_wdat0 !== 32'hCC || wb_wdat1 !== 32'hDD || wb_vl !== 32'd9) begin
         bad++;
         $display("FAIL stall_release got=%h,%h vl=%0d want=cc,dd 9", wb_wdat0, wb_wdat1, wb_vl);
      end
      clear_inputs();
   endtask

   task automatic test_flush();
      load = 1; ena0 = 1; ena1 = 1; wen0 = 1; wen1 = 1;
      aluresult0 = 32'h100; aluresult1 = 32'h104;
      vl = 32'd4; vtype = 8'h11; config_type = 1;
      @(posedge CLK);
      @(posedge CLK);
      @(negedge CLK);
      total++;
      if (dmem_ren !== 1'b1 || dmem_addr !== 32'h104) begin
         bad++; $display("FAIL fl_lane1 got ren=%b addr=%h want 1 104", dmem_ren, dmem_addr);
      end
      flush_mem = 1;
      @(posedge CLK); #1;
      total++;
      if (dmem_ren !== 1'b0) begin
         bad++; $display("FAIL fl_ren got=%b want=0", dmem_ren);
      end
      clear_inputs();
      @(negedge CLK);
      total++;
      if ({wb_wen0, wb_wen1, wb_config_type, busy_mem} !== 4'b0000 || wb_wdat0 !== 0 ||
          wb_wdat1 !== 0 || wb_vl !== 0 || wb_vtype !== 0) begin
         bad++;
         $display("FAIL fl_wb got wdat=%h,%h vl=%0d vt=%h busy=%b want zeros",
                  wb_wdat0, wb_wdat1, wb_vl, wb_vtype, busy_mem);
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_async_reset();
      load = 1; ena0 = 1; ena1 = 1; wen0 = 1; wen1 = 1;
      aluresult0 = 32'h100; aluresult1 = 32'h104;
      @(posedge CLK); #1;
      total++;
      if (dmem_ren !== 1'b1) begin
         bad++; $display("FAIL ar_pre got ren=%b want 1", dmem_ren);
      end
      #1 nRST = 0;
      #1;
      total++;
      if (dmem_ren !== 1'b0 || dmem_wen !== 1'b0) begin
         bad++; $display("FAIL ar_req got ren=%b wen=%b want 0 0", dmem_ren, dmem_wen);
      end
      clear_inputs();
      @(negedge CLK); nRST = 1;
      @(posedge CLK); #1;
   endtask

`ifdef RV32V_MEM_ALIGN_CHECK_EN
   task automatic test_align();
      load = 1; ena0 = 1; ena1 = 1; wen0 = 1; wen1 = 1;
      aluresult0 = 32'h102; aluresult1 = 32'h104;
      @(posedge CLK);
      @(negedge CLK);
      total++;
      if (dmem_ren !== 1'b0) begin
         bad++; $display("FAIL al_lane0 got ren=%b want 0", dmem_ren);
      end
      @(negedge CLK);
      total++;
      if (dmem_ren !== 1'b1 || dmem_addr !== 32'h104) begin
         bad++; $display("FAIL al_lane1 got ren=%b addr=%h want 1 104", dmem_ren, dmem_addr);
      end
      @(negedge CLK);
      total++;
      if (misaligned !== 1'b1) begin
         bad++; $display("FAIL al_flag got=%b want=1", misaligned);
      end
      @(posedge CLK); #1;
      total++;
      if (misaligned !== 1'b0 || {wb_wen0, wb_wen1} !== 2'b01 || wb_wdat0 !== 0 ||
          wb_wdat1 !== 32'hBB) begin
         bad++;
         $display("FAIL al_wb got mis=%b wen=%b wdat=%h,%h want 0 01 0,bb",
                  misaligned, {wb_wen0, wb_wen1}, wb_wdat0, wb_wdat1);
      end
      clear_inputs();
   endtask
`endif

   initial begin
      test_reset();
      test_alu();
      test_load2();
      test_load1();
      test_store_wait();
      test_stall();
      test_flush();
      test_async_reset();
`ifdef RV32V_MEM_ALIGN_CHECK_EN
      test_align();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
